// File: rtl/zpu_rom_word_fetch_pkg.sv
// Shared definitions for the ZPU boot-ROM word fetch block:
// state encoding, word size and big-endian byte-lane mapping.
package zpu_rom_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int ZPU_WORD_BYTES = 4;

  // Byte k of a word (k=0 at the base address) lands in the most significant lane first.
  function automatic logic [1:0] lane(input logic [1:0] k);
    return 2'd3 - k;
  endfunction

endpackage

// File: rtl/zpu_rom_word_fetch_if.sv
// Request/response handshake bundle between the ZPU memory interface
// (master) and the ROM word fetch block (slave).
interface zpu_rom_word_fetch_if #(
  parameter int addr_width = 9
);

  logic                  req_valid;
  logic                  req_ready;
  logic [addr_width-1:0] req_addr;
  logic                  req_byte;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;

  modport master (
    output req_valid, req_addr, req_byte, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_byte, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/zpu_rom_word_fetch_lat_pipe.sv
// Valid-bit shift register mirroring the ROM read latency: an issue strobe
// entering now emerges as a capture strobe exactly depth cycles later.
module zpu_rom_lat_pipe #(
  parameter int depth = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_strobe,
  output logic capture_strobe
);

  logic [depth-1:0] pipe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | depth'(issue_strobe);
    end
  end

  assign capture_strobe = pipe_q[depth-1];

endmodule

// File: rtl/zpu_rom_word_fetch.sv
// Turns ZPU word/byte reads into a sequence of byte reads on the latency-2
// boot ROM and returns a big-endian 32-bit response over valid/ready.
module zpu_rom_word_fetch
  import zpu_rom_pkg::*;
#(
  parameter int addr_width  = 9,
  parameter int rom_latency = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  zpu_rom_word_fetch_if.slave   bus,
  output logic [addr_width-1:0] rom_addr,
  input  logic [7:0]            rom_dout
);

  logic [1:0]            state;
  logic                  byte_mode;
  logic [1:0]            issue_cnt;
  logic [1:0]            cap_cnt;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_data_q;
  logic                  accept;
  logic                  issue_strobe;
  logic                  capture_strobe;
  logic [1:0]            last_idx;
  logic [addr_width-1:0] req_base;

  assign bus.req_ready = (state == ST_IDLE) && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  assign accept       = bus.req_valid && bus.req_ready;
  assign issue_strobe = (state == ST_ISSUE);
  assign last_idx     = byte_mode ? 2'd0 : 2'(ZPU_WORD_BYTES - 1);
  assign req_base     = bus.req_byte ? bus.req_addr
                                     : {bus.req_addr[addr_width-1:2], 2'b00};

  zpu_rom_lat_pipe #(
    .depth (rom_latency)
  ) u_lat_pipe (
    .clk            (clk),
    .reset          (reset),
    .issue_strobe   (issue_strobe),
    .capture_strobe (capture_strobe)
  );

  // rom_addr is loaded at acceptance so the first byte address is on the ROM
  // in the cycle right after the handshake; it then steps once per issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      byte_mode   <= 1'b0;
      issue_cnt   <= 2'd0;
      cap_cnt     <= 2'd0;
      rom_addr    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_ISSUE;
            byte_mode  <= bus.req_byte;
            rom_addr   <= req_base;
            issue_cnt  <= 2'd0;
            cap_cnt    <= 2'd0;
            rsp_data_q <= 32'h0;
          end
        end
        ST_ISSUE: begin
          if (issue_cnt == last_idx) begin
            state <= ST_DRAIN;
          end else begin
            issue_cnt <= issue_cnt + 2'd1;
            rom_addr  <= rom_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (capture_strobe && (cap_cnt == last_idx)) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Captures can start while still issuing when the ROM latency is short.
      if (capture_strobe) begin
        cap_cnt <= cap_cnt + 2'd1;
        if (byte_mode) begin
          rsp_data_q <= {24'h0, rom_dout};
        end else begin
          rsp_data_q[{lane(cap_cnt), 3'b000} +: 8] <= rom_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_zpu_rom_word_fetch.sv
// Self-checking bench: a transaction-level model predicts every cycle's
// outputs, and directed reads pin data, latency and address sequences.
module tb_zpu_rom_word_fetch;

  localparam int AW  = 9;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_dout = 8'h0;
  logic [7:0]    rom_stage = 8'h0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fails = 0;

  zpu_rom_word_fetch_if #(.addr_width(AW)) bus ();

  zpu_rom_word_fetch #(
    .addr_width  (AW),
    .rom_latency (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] romByte(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Two-stage ROM: data for an address appears two cycles after it is presented.
  always @(posedge clk) begin
    rom_stage <= romByte(rom_addr);
    rom_dout  <= rom_stage;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Transaction-level model: one outstanding request, known accept cycle,
  // response due N + LAT + 1 cycles later, data computed straight from the ROM contents.
  logic          m_busy = 1'b0;
  int            m_tacc = 0;
  int            m_n = 0;
  logic [AW-1:0] m_base = '0;
  logic [31:0]   m_data = 32'h0;
  logic [AW-1:0] m_rom = '0;

  always @(negedge clk) begin
    logic exp_valid;
    if (reset) begin
      m_busy = 1'b0;
      m_rom  = '0;
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("rst_rsp_data", bus.rsp_data, 32'h0);
      checkOutput("rst_rom_addr", 32'(rom_addr), 32'h0);
    end else begin
      if (m_busy && cyc >= m_tacc + 1 && cyc <= m_tacc + m_n)
        m_rom = AW'(m_base + AW'(cyc - m_tacc - 1));
      exp_valid = m_busy && (cyc >= m_tacc + m_n + LAT + 1);
      checkOutput("model_rom_addr", 32'(rom_addr), 32'(m_rom));
      checkOutput("model_req_ready", 32'(bus.req_ready), 32'(!m_busy));
      checkOutput("model_rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      if (exp_valid) checkOutput("model_rsp_data", bus.rsp_data, m_data);
      if (!m_busy && bus.req_valid) begin
        m_busy = 1'b1;
        m_tacc = cyc;
        if (bus.req_byte) begin
          m_n    = 1;
          m_base = bus.req_addr;
          m_data = {24'h0, romByte(bus.req_addr)};
        end else begin
          m_n    = 4;
          m_base = {bus.req_addr[AW-1:2], 2'b00};
          m_data = {romByte(m_base), romByte(AW'(m_base + 1)),
                    romByte(AW'(m_base + 2)), romByte(AW'(m_base + 3))};
        end
      end else if (exp_valid && bus.rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // One read with literal expectations for data, response latency,
  // optionally the issued address sequence, and a backpressure hold.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic is_byte,
                               input int stall, input logic [31:0] exp_word,
                               input int exp_lat, input logic check_seq);
    int waited;
    int lat;
    logic [AW-1:0] seq [4];
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_byte  = is_byte;
    bus.rsp_ready = 1'b0;
    waited = 0;
    while (waited < 50) begin
      @(negedge clk);
      if (bus.req_ready) break;
      waited++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (waited >= 50) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat <= 4) seq[lat-1] = rom_addr;
      if (bus.rsp_valid) break;
    end
    checkOutput("rsp_latency", 32'(lat), 32'(exp_lat));
    checkOutput("rsp_data", bus.rsp_data, exp_word);
    if (check_seq) begin
      for (int i = 0; i < 4; i++)
        checkOutput("rom_addr_seq", 32'(seq[i]), 32'(addr + AW'(i)));
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("stall_rsp_data", bus.rsp_data, exp_word);
      checkOutput("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic applyResetMidWord();
    int waited;
    int seen_valid;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 9'h020;
    bus.req_byte  = 1'b0;
    waited = 0;
    while (waited < 50) begin
      @(negedge clk);
      if (bus.req_ready) break;
      waited++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_valid++;
    end
    checkOutput("post_reset_no_rsp", 32'(seen_valid), 32'd0);
  endtask

  task automatic applyBackToBack();
    int accepts = 0;
    int resps = 0;
    int h_cyc = 0;
    int a_cyc = 0;
    int n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 9'h000;
    bus.req_byte  = 1'b0;
    bus.rsp_ready = 1'b1;
    while (resps < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        resps++;
        if (resps == 1) begin
          h_cyc = cyc;
          checkOutput("b2b_first_data", bus.rsp_data, 32'hA5A4A7A6);
        end else begin
          checkOutput("b2b_second_data", bus.rsp_data, 32'hA1A0A3A2);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        accepts++;
        if (accepts == 2) a_cyc = cyc;
        @(posedge clk); #1;
        if (accepts == 1) bus.req_addr = 9'h004;
        else bus.req_valid = 1'b0;
      end
    end
    checkOutput("b2b_done", 32'(resps), 32'd2);
    checkOutput("b2b_accept_gap", 32'(a_cyc - h_cyc), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_byte  = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(9'h010, 1'b0, 0, 32'hB5B4B7B6, 7, 1'b1);
    applyStimulus(9'h013, 1'b0, 0, 32'hB5B4B7B6, 7, 1'b0);
    applyStimulus(9'h1FF, 1'b1, 0, 32'h0000005A, 4, 1'b0);
    applyStimulus(9'h1FC, 1'b0, 10, 32'h59585B5A, 7, 1'b1);
    applyResetMidWord();
    applyStimulus(9'h000, 1'b0, 0, 32'hA5A4A7A6, 7, 1'b1);
    applyBackToBack();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/zpu_rom_word_fetch.md
Name: zpu_rom_word_fetch

Overview:
- Sits directly downstream of the ZPU boot ROM, which is a byte-wide synchronous ROM with a total read latency of 2 cycles.
- Accepts word or byte read requests from the ZPU memory interface.
- Sequences the byte addresses into the ROM and tracks the in-flight bytes through the ROM latency.
- Assembles a big-endian 32-bit response and returns it with a valid/ready handshake.

Parameters:
- addr_width, 9: width of the ROM byte address; 512-byte ROM.
- rom_latency, 2: cycles from a rom_addr value to the matching rom_dout value; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  addr_width  byte address of the request.
- req_byte  in  1  1 = single-byte read; 0 = 32-bit word read.
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  response word; a byte read returns {24'h0, byte}.
- rom_addr  out  addr_width  registered byte address to the ROM.
- rom_dout  in  8  ROM data; corresponds to the rom_addr value from rom_latency cycles earlier.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - rsp_valid=0, rsp_data=0, rom_addr=0, issue counter=0, capture counter=0, latency pipe cleared.
  - req_ready=0 while reset is asserted; 1 from the first cycle after reset deasserts.
- Request acceptance:
  - A request is accepted on a cycle T where req_valid & req_ready.
  - Word mode forces the base address low 2 bits to 0; byte mode uses req_addr unchanged.
  - The req_byte value is latched with the address.
- States:
  - IDLE: req_ready=1. On accept, go to ISSUE.
  - ISSUE: drive rom_addr = base+k for k = 0..N-1, one per cycle, from T+1 to T+N. N=4 for word, N=1 for byte. Each issue pushes a "valid" bit into a rom_latency-deep shift pipe. After the last issue, go to DRAIN.
  - DRAIN: wait for the remaining in-flight bytes, then go to RESP.
  - RESP: rsp_valid=1; rsp_data is held stable. When rsp_ready=1, go to IDLE on the next edge.
- Byte capture:
  - When the pipe output is valid, capture rom_dout.
  - Word mode: capture k goes to rsp_data[31-8k -: 8], so base+0 is the MSB (big-endian).
  - Byte mode: rsp_data = {24'h0, rom_dout}.
- Latency (rom_latency=2):
  - Word: bytes captured at the ends of T+3 .. T+6; rsp_valid rises at T+7.
  - Byte: captured at the end of T+3; rsp_valid rises at T+4.
  - General formula: rsp_valid first high at T + N + rom_latency + 1.
- Address arithmetic: base+k wraps modulo 2^addr_width. For example, word 0x1FC reads 0x1FC..0x1FF; byte reads do not cross words.
- rom_addr holds its last issued value outside ISSUE. It never changes while the block is in IDLE.
- No new request is accepted while busy, and there is no back-to-back overlap. rsp_ready=1 in RESP and req_valid=1 in the same cycle does not accept a request; acceptance occurs no earlier than the next cycle (IDLE).
- rsp_ready held low leaves rsp_valid and rsp_data stable indefinitely.
- Reset asserted mid-ISSUE, mid-DRAIN or mid-RESP: in-flight bytes are discarded and no response is produced after reset.

Decomposition:
- Shared package zpu_rom_pkg holds:
  - state encoding: IDLE, ISSUE, DRAIN, RESP;
  - ZPU_WORD_BYTES=4;
  - byte-lane index function: lane(k) = 3-k.
- One sub-module, zpu_rom_lat_pipe: a rom_latency-deep valid shift register with asynchronous reset. Input is the issue strobe; output is the capture strobe.

Test Plan:
- The bench ROM model has 2-cycle latency, with mem[i] = i ^ 8'hA5.
- Word read, addr 0x010 -> rsp_data=32'hB5B4B7B6; rsp_valid first high at T+7; rom_addr sequence 0x010, 0x011, 0x012, 0x013.
- Unaligned word read, addr 0x013 -> treated as 0x010; same data 32'hB5B4B7B6.
- Byte read, addr 0x1FF -> rsp_data=32'h0000005A; rsp_valid at T+4.
- Backpressure: rsp_ready low for 10 cycles -> rsp_valid and rsp_data stable; req_ready=0 throughout.
- Reset asserted at T+4 of a word read -> rsp_valid stays 0; req_ready=1 on the first cycle after release. A fresh read of 0x000 then returns 32'hA5A4A7A6.
- Back-to-back reads 0x000 then 0x004 with req_valid held high -> second accept no earlier than the cycle after the first RESP handshake. Responses are 32'hA5A4A7A6 then 32'hA1A0A3A2.
